// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction fetch queue
package if_pkg;

    localparam int IF_PC_W = 32;
    localparam int IF_IW   = 16;

    // Opcode occupies the top OPC_W bits of an instruction word.
    localparam int OPC_W = 4;

    typedef enum logic {
        S_OP,
        S_IMM
    } fetch_state_e;

    typedef enum logic [2:0] {
        REDIR_NONE,
        REDIR_EXC,
        REDIR_POP,
        REDIR_JMP,
        REDIR_INT
    } redir_src_e;

    // Queue entry at the default widths; the top declares the same layout at its own widths.
    typedef struct packed {
        logic [IF_IW-1:0]   instr;
        logic [IF_IW-1:0]   imm;
        logic               itype;
        logic               is_int;
        logic [IF_PC_W-1:0] pc_next;
    } fetch_pkt_t;

    function automatic redir_src_e redir_select(input logic exc, input logic pop, input logic jmp);
        if (exc) return REDIR_EXC;
        if (pop) return REDIR_POP;
        if (jmp) return REDIR_JMP;
        return REDIR_NONE;
    endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - instruction memory and ID-side packet bus of the fetch queue
interface if_fetch_queue_if #(
    parameter int PC_W = 32,
    parameter int IW   = 16
);
    logic [PC_W-1:0] imem_addr;
    logic [IW-1:0]   imem_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [IW-1:0]   out_instr;
    logic [IW-1:0]   out_imm;
    logic            out_itype;
    logic            out_int;
    logic [PC_W-1:0] out_pc_next;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_imm,
        output out_itype,
        output out_int,
        output out_pc_next
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_imm,
        input  out_itype,
        input  out_int,
        input  out_pc_next
    );
endinterface

// File: rtl/if_fetch_fifo.sv
// rtl/if_fetch_fifo.sv - DEPTH-entry circular packet buffer, falling-edge clocked, flush wins over push
module if_fetch_fifo
    import if_pkg::*;
#(
    parameter type entry_t = fetch_pkt_t,
    parameter int  DEPTH   = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    input  logic   flush,
    output entry_t head,
    output logic   full,
    output logic   empty
);
    localparam int AW = $clog2(DEPTH);

    entry_t         mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(negedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - fetch stage with packet queue toward ID; IF_PERF_CNT_EN adds perf counters
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int               PC_W      = 32,
    parameter int               IW        = 16,
    parameter int               DEPTH     = 4,
    parameter logic [OPC_W-1:0] ITYPE_OP  = 4'd8,
    parameter logic [PC_W-1:0]  RESET_VEC = PC_W'(32),
    parameter logic [PC_W-1:0]  EXC_VEC   = PC_W'(32),
    parameter logic [PC_W-1:0]  INT_VEC   = PC_W'(0)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            interrupt,
    input  logic            set_int,
    input  logic            exception,
    input  logic            pop_pc,
    input  logic [PC_W-1:0] pc_pop_val,
    input  logic            jmp,
    input  logic [PC_W-1:0] pc_jmp_val,
    if_fetch_queue_if.master bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [15:0]     perf_redir_cnt
`endif
);
    typedef struct packed {
        logic [IW-1:0]   instr;
        logic [IW-1:0]   imm;
        logic            itype;
        logic            is_int;
        logic [PC_W-1:0] pc_next;
    } pkt_t;

    fetch_state_e    state, state_n;
    logic [PC_W-1:0] pc, pc_n, pc_inc;
    logic [IW-1:0]   hold, hold_n;
    logic            int_pend, int_take;
    logic            push, pop, flush, full, empty, push_ok, out_valid;
    pkt_t            push_pkt, head;
    redir_src_e      redir_src, redir_kind;

    assign pc_inc    = pc + PC_W'(1);
    assign redir_src = redir_select(exception, pop_pc, jmp);

    // A redirect in flight hides the queue head so ID never consumes a packet about to be flushed.
    assign out_valid = !empty && (redir_src == REDIR_NONE);
    assign pop       = out_valid && bus.out_ready;
    assign push_ok   = !full || pop;

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        hold_n     = hold;
        push       = 1'b0;
        push_pkt   = '0;
        flush      = 1'b0;
        int_take   = 1'b0;
        redir_kind = redir_src;
        if (redir_src == REDIR_NONE && state == S_OP && int_pend && push_ok)
            redir_kind = REDIR_INT;

        case (redir_kind)
            REDIR_EXC, REDIR_POP, REDIR_JMP: begin
                flush   = 1'b1;
                hold_n  = '0;
                state_n = S_OP;
                if (redir_kind == REDIR_EXC)      pc_n = EXC_VEC;
                else if (redir_kind == REDIR_POP) pc_n = pc_pop_val;
                else                              pc_n = pc_jmp_val;
            end
            REDIR_INT: begin
                push             = 1'b1;
                push_pkt.is_int  = 1'b1;
                push_pkt.pc_next = pc;
                pc_n             = INT_VEC;
                int_take         = 1'b1;
            end
            default: begin
                if (state == S_OP) begin
                    // The opcode word of an I-type only moves into hold, so it needs no queue room.
                    if (bus.imem_rdata[IW-1 -: OPC_W] == ITYPE_OP) begin
                        hold_n  = bus.imem_rdata;
                        pc_n    = pc_inc;
                        state_n = S_IMM;
                    end else if (push_ok) begin
                        push             = 1'b1;
                        push_pkt.instr   = bus.imem_rdata;
                        push_pkt.pc_next = pc_inc;
                        pc_n             = pc_inc;
                    end
                end else if (push_ok) begin
                    push             = 1'b1;
                    push_pkt.instr   = hold;
                    push_pkt.imm     = bus.imem_rdata;
                    push_pkt.itype   = 1'b1;
                    push_pkt.pc_next = pc_inc;
                    pc_n             = pc_inc;
                    state_n          = S_OP;
                end
            end
        endcase
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_OP;
            pc       <= RESET_VEC;
            hold     <= '0;
            int_pend <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            hold     <= hold_n;
            int_pend <= (int_pend && !int_take) || interrupt || set_int;
        end
    end

    if_fetch_fifo #(
        .entry_t (pkt_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_pkt),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign bus.imem_addr   = pc;
    assign bus.out_valid   = out_valid;
    assign bus.out_instr   = out_valid ? head.instr   : '0;
    assign bus.out_imm     = out_valid ? head.imm     : '0;
    assign bus.out_itype   = out_valid ? head.itype   : 1'b0;
    assign bus.out_int     = out_valid ? head.is_int  : 1'b0;
    assign bus.out_pc_next = out_valid ? head.pc_next : '0;

`ifdef IF_PERF_CNT_EN
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_cnt <= '0;
            perf_redir_cnt <= '0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'(push && !push_pkt.is_int);
            perf_redir_cnt <= perf_redir_cnt + 16'(redir_kind != REDIR_NONE);
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - scoreboard bench for if_fetch_queue
module tb_if_fetch_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        interrupt = 1'b0, set_int = 1'b0;
    logic        exception = 1'b0, pop_pc = 1'b0, jmp = 1'b0;
    logic [31:0] pc_pop_val = '0, pc_jmp_val = '0;
    int          n_tests = 0, n_fail = 0, n_pop = 0;
    logic [65:0] exp_q[$];
    logic [31:0] a;
    int          pop_mark;

    if_fetch_queue_if #(.PC_W(32), .IW(16)) bus();

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [15:0] perf_redir_cnt;
`endif

    if_fetch_queue #(
        .PC_W(32), .IW(16), .DEPTH(4), .ITYPE_OP(4'd8),
        .RESET_VEC(32'd32), .EXC_VEC(32'd32), .INT_VEC(32'd0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .interrupt  (interrupt),
        .set_int    (set_int),
        .exception  (exception),
        .pop_pc     (pop_pc),
        .pc_pop_val (pc_pop_val),
        .jmp        (jmp),
        .pc_jmp_val (pc_jmp_val),
        .bus        (bus)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_redir_cnt (perf_redir_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Program image: I-type pairs at 40/41 and 50/51, plain one-word ops elsewhere.
    function automatic logic [15:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'd40:  return 16'h8123;
            32'd41:  return 16'hBEEF;
            32'd50:  return 16'h8456;
            32'd51:  return 16'h1234;
            default: return {4'h1, addr[11:0]};
        endcase
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_one(inout logic [31:0] addr);
        logic [15:0] w;
        w = mem_word(addr);
        if (w[15:12] == 4'h8) begin
            exp_q.push_back({w, mem_word(addr + 32'd1), 2'b10, addr + 32'd2});
            addr = addr + 32'd2;
        end else begin
            exp_q.push_back({w, 16'h0, 2'b00, addr + 32'd1});
            addr = addr + 32'd1;
        end
    endtask

    task automatic push_bubble(input logic [31:0] ret);
        exp_q.push_back({16'h0, 16'h0, 2'b01, ret});
    endtask

    task automatic wait_addr(input logic [31:0] target, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (bus.imem_addr == target) begin
                found = 1'b1;
                break;
            end
        end
        check_eq(tag, found, 1);
    endtask

    // Handshakes complete on the falling edge; sample between rising edge and that edge.
    initial begin
        logic [65:0] e;
        forever begin
            @(posedge clk);
            #3;
            if (reset && bus.out_valid && bus.out_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_pkt", {bus.out_instr, bus.out_imm, bus.out_itype, bus.out_int, bus.out_pc_next}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("pkt", {bus.out_instr, bus.out_imm, bus.out_itype, bus.out_int, bus.out_pc_next}, e);
                end
            end
        end
    end

    initial begin
        #100000;
        check_eq("timeout", 0, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", bus.out_valid, 0);
        check_eq("rst_addr", bus.imem_addr, 32);
        check_eq("rst_pc_next", bus.out_pc_next, 0);
        check_eq("rst_instr", bus.out_instr, 0);

        // Linear run from 32, I-type at 40 and 50, interrupt bubble after 50/51, then INT_VEC.
        a = 32'd32;
        while (a != 32'd52) push_one(a);
        push_bubble(32'd52);
        a = 32'd0;
        repeat (20) push_one(a);
        @(posedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("addr_33", bus.imem_addr, 33);
        @(posedge clk); #1;
        check_eq("addr_34", bus.imem_addr, 34);
        wait_addr(32'd51, "reach_s_imm_51");
        interrupt = 1'b1;
        @(posedge clk);
        interrupt = 1'b0;
        @(posedge clk); #1;
        check_eq("int_vec_fetch", bus.imem_addr, 0);
        repeat (15) @(posedge clk);

        // Back-pressure: jump to 0x200 with ID stalled, queue fills to DEPTH and PC freezes.
        bus.out_ready = 1'b0;
        jmp = 1'b1;
        pc_jmp_val = 32'h200;
        exp_q.delete();
        a = 32'h200;
        repeat (20) push_one(a);
        #1;
        check_eq("jmp_hides_valid", bus.out_valid, 0);
        @(posedge clk);
        jmp = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("full_addr_frozen", bus.imem_addr, 32'h204);
        check_eq("full_valid", bus.out_valid, 1);
        check_eq("full_head", bus.out_pc_next, 32'h201);
        bus.out_ready = 1'b1;
        pop_mark = n_pop;
        repeat (12) @(posedge clk);
        check_eq("drain_count", n_pop - pop_mark, 12);

        // Jump and interrupt on the same edge: redirect first, bubble returns to 0x100.
        jmp = 1'b1;
        interrupt = 1'b1;
        pc_jmp_val = 32'h100;
        exp_q.delete();
        push_bubble(32'h100);
        a = 32'd0;
        repeat (20) push_one(a);
        #1;
        check_eq("jmp_int_valid", bus.out_valid, 0);
        @(posedge clk);
        jmp = 1'b0;
        interrupt = 1'b0;
        #1;
        check_eq("jmp_target", bus.imem_addr, 32'h100);
        repeat (12) @(posedge clk);

        // Exception beats pop_pc with a full queue.
        bus.out_ready = 1'b0;
        repeat (8) @(posedge clk);
        exception = 1'b1;
        pop_pc = 1'b1;
        pc_pop_val = 32'h300;
        exp_q.delete();
        a = 32'd32;
        repeat (20) push_one(a);
        #1;
        check_eq("exc_valid", bus.out_valid, 0);
        @(posedge clk);
        exception = 1'b0;
        pop_pc = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check_eq("exc_vec", bus.imem_addr, 32);
        check_eq("exc_flushed", bus.out_valid, 0);

        // Asynchronous reset while waiting on an immediate word.
        wait_addr(32'd41, "reach_s_imm_41");
        reset = 1'b0;
        exp_q.delete();
        #1;
        check_eq("areset_addr", bus.imem_addr, 32);
        check_eq("areset_valid", bus.out_valid, 0);
        check_eq("areset_instr", bus.out_instr, 0);
        a = 32'd32;
        repeat (10) push_one(a);
        repeat (2) @(posedge clk);
        reset = 1'b1;
        pop_mark = n_pop;
        repeat (8) @(posedge clk);
        check_eq("post_reset_count", n_pop - pop_mark, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
